// File: rtl/spi_master.sv
// Mode-0 SPI master: one W-bit full-duplex transfer per accepted start pulse.
// Optional macro SPI_MASTER_LSB_FIRST_EN shifts LSB first; default is MSB first.
module spi_master #(
    parameter int W       = 8,
    parameter int CLK_DIV = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] tx_data,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rx_data,
    output logic         sclk,
    output logic         cs_n,
    output logic         mosi,
    input  logic         miso
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(W) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [W-1:0]     tx_q, tx_d;
    logic [W-1:0]     rx_shift_q, rx_shift_d;
    logic [W-1:0]     rx_data_q, rx_data_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic div_wrap;
    logic last_bit;
    logic accept;
    logic rise_edge;
    logic fall_edge;
    logic finish;

    // Phase events: the SETUP exit edge doubles as the first sclk rising edge.
    assign div_wrap  = (div_q == DIV_LAST);
    assign last_bit  = (bit_q == BIT_LAST);
    assign accept    = (state_q == IDLE) && start;
    assign rise_edge = div_wrap && ((state_q == SETUP) ||
                                    ((state_q == XFER) && !sclk_q && !last_bit));
    assign fall_edge = div_wrap && (state_q == XFER) && sclk_q;
    assign finish    = div_wrap && (state_q == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SETUP;
            SETUP:   if (div_wrap) state_d = XFER;
            XFER:    if (div_wrap && !sclk_q && last_bit) state_d = HOLD;
            HOLD:    if (div_wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d      = div_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = finish;

        if ((state_q == IDLE) || (state_d != state_q) || div_wrap) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        if ((state_q == SETUP) && (state_d == XFER)) begin
            bit_d = '0;
        end else if (rise_edge) begin
            bit_d = bit_q + 1'b1;
        end

        if (rise_edge) begin
            sclk_d = 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
            rx_shift_d = {miso, rx_shift_q[W-1:1]};
`else
            rx_shift_d = {rx_shift_q[W-2:0], miso};
`endif
        end else if (fall_edge) begin
            sclk_d = 1'b0;
        end

        // The final falling edge leaves the last bit on mosi through HOLD.
        if (accept) begin
            tx_d = tx_data;
        end else if (fall_edge && !last_bit) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
            tx_d = {1'b0, tx_q[W-1:1]};
`else
            tx_d = {tx_q[W-2:0], 1'b0};
`endif
        end else if (finish) begin
            tx_d = '0;
        end

        if (accept) begin
            cs_n_d = 1'b0;
            busy_d = 1'b1;
        end else if (finish) begin
            cs_n_d    = 1'b1;
            busy_d    = 1'b0;
            rx_data_d = rx_shift_q;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign mosi    = tx_q[0];
`else
    assign mosi    = tx_q[W-1];
`endif

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a driver pushes the expected word, latency and
// mosi bit stream per transfer; a negedge monitor pops and compares them.
module tb_spi_master;

    localparam int W       = 8;
    localparam int CLK_DIV = 2;
    localparam int LAT     = (2 * W + 2) * CLK_DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         busy, done, sclk, cs_n, mosi, miso;
    logic [W-1:0] rx_data;

    // 0: miso looped back from mosi, 1: miso tied low, 2: miso tied high
    int miso_mode = 0;
    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 2);

    spi_master #(.W(W), .CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int done_count = 0;
    int rise_count = 0;
    int cs_low = 0;
    logic prev_sclk = 1'b0;

    typedef struct {
        logic [W-1:0] rx;
        int           accept;
    } exp_t;

    exp_t exp_q[$];
    logic mosi_exp_q[$];
    exp_t mon_e;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    function automatic logic [W-1:0] modelRx(input logic [W-1:0] tx, input int mode);
        if (mode == 0) return tx;
        if (mode == 1) return '0;
        return '1;
    endfunction

    // Expected wire order of the transmitted word.
    task automatic pushExpected(input logic [W-1:0] tx, input int mode, input int acc);
        exp_t e;
        e.rx     = modelRx(tx, mode);
        e.accept = acc;
        exp_q.push_back(e);
        for (int i = 0; i < W; i++) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
            mosi_exp_q.push_back(tx[i]);
`else
            mosi_exp_q.push_back(tx[W-1-i]);
`endif
        end
    endtask

    // Drives one start pulse; returns just after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] tx, input int mode);
        miso_mode = mode;
        tx_data   = tx;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pushExpected(tx, mode, cycle);
    endtask

    task automatic waitDone(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles", limit);
        end
    endtask

    // Monitor: mosi at each sclk rise, word/latency/edge count at each done.
    always @(negedge clk) begin
        if (rst) begin
            rise_count = 0;
            cs_low     = 0;
            prev_sclk  = 1'b0;
        end else begin
            if (sclk && !prev_sclk) begin
                rise_count++;
                if (mosi_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_sclk_rise: got rise, expected none");
                end else begin
                    checkOutput("mosi_bit", {31'b0, mosi}, {31'b0, mosi_exp_q.pop_front()});
                end
            end
            prev_sclk = sclk;

            if (!cs_n) begin
                cs_low++;
            end else if (cs_low != 0) begin
                checkOutput("cs_low_cycles", cs_low, LAT);
                cs_low = 0;
            end

            if (done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done, expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("rx_data", {24'b0, rx_data}, {24'b0, mon_e.rx});
                    checkOutput("done_latency", cycle - mon_e.accept, LAT);
                    checkOutput("sclk_rises", rise_count, W);
                end
                rise_count = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        int acc;
        logic [W-1:0] rtx;
        int rmode;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'b0, busy}, 0);
        checkOutput("reset_done", {31'b0, done}, 0);
        checkOutput("reset_rx", {24'b0, rx_data}, 0);
        checkOutput("reset_sclk", {31'b0, sclk}, 0);
        checkOutput("reset_cs_n", {31'b0, cs_n}, 1);
        checkOutput("reset_mosi", {31'b0, mosi}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        applyStimulus(8'hA5, 0);
        checkOutput("accept_busy", {31'b0, busy}, 1);
        checkOutput("accept_mosi_first", {31'b0, mosi},
`ifdef SPI_MASTER_LSB_FIRST_EN
                    1);
`else
                    1);
`endif
        waitDone(LAT + 10);
        checkOutput("done_busy_low", {31'b0, busy}, 0);
        checkOutput("done_mosi_low", {31'b0, mosi}, 0);

        applyStimulus(8'h00, 2);
        waitDone(LAT + 10);
        applyStimulus(8'hFF, 1);
        waitDone(LAT + 10);
        applyStimulus(8'h01, 0);
        waitDone(LAT + 10);

        // Starts during SETUP and during bit 4 must be ignored.
        repeat (2) @(posedge clk);
        #1;
        d0 = done_count;
        applyStimulus(8'hA5, 0);
        start   = 1'b1;
        tx_data = 8'h3C;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(LAT + 10);
        repeat (LAT + 5) @(posedge clk);
        #1;
        checkOutput("ignored_start_done_count", done_count - d0, 1);
        checkOutput("ignored_start_rx_held", {24'b0, rx_data}, 32'hA5);

        // Abort in bit 3 (sclk high phase) with an asynchronous reset.
        applyStimulus(8'hC3, 0);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("midxfer_busy", {31'b0, busy}, 1);
        checkOutput("midxfer_sclk", {31'b0, sclk}, 1);
        exp_q.delete();
        mosi_exp_q.delete();
        d0  = done_count;
        rst = 1'b1;
        #1;
        checkOutput("abort_cs_n", {31'b0, cs_n}, 1);
        checkOutput("abort_sclk", {31'b0, sclk}, 0);
        checkOutput("abort_busy", {31'b0, busy}, 0);
        checkOutput("abort_rx", {24'b0, rx_data}, 0);
        checkOutput("abort_mosi", {31'b0, mosi}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        checkOutput("abort_no_done", done_count - d0, 0);
        applyStimulus(8'h5A, 0);
        waitDone(LAT + 10);

        // Back-to-back transfers with start held high through done.
        miso_mode = 0;
        tx_data   = 8'h81;
        start     = 1'b1;
        @(posedge clk);
        #1;
        acc     = cycle;
        tx_data = 8'h7E;
        pushExpected(8'h81, 0, acc);
        pushExpected(8'h7E, 0, acc + LAT + 1);
        waitDone(LAT + 10);
        checkOutput("b2b_cs_n_gap", {31'b0, cs_n}, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_cs_n_relow", {31'b0, cs_n}, 0);
        checkOutput("b2b_busy", {31'b0, busy}, 1);
        waitDone(LAT + 10);

        for (int n = 0; n < 8; n++) begin
            rtx   = W'($urandom);
            rmode = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            applyStimulus(rtx, rmode);
            waitDone(LAT + 10);
        end

        repeat (10) @(posedge clk);
        #1;
        checkOutput("pending_words", exp_q.size(), 0);
        checkOutput("pending_bits", mosi_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
